// File: rtl/full_adder_if.sv
// Operand/result bundle for the registered full adder.
// The producer drives the operands and in_valid; the adder drives the result fields.
interface full_adder_if #(
    parameter int WIDTH = 1
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             out_valid;

    modport master (
        output in_valid, a, b, cin,
        input  sum, carry, out_valid
    );

    modport slave (
        input  in_valid, a, b, cin,
        output sum, carry, out_valid
    );
endinterface

// File: rtl/full_adder.sv
// Registered ripple-carry full adder.
// {carry, sum} = a + b + cin, produced LATENCY clocks after the operands are
// sampled. The carry chain is cut into LATENCY slices; slice k handles bits
// [ceil(WIDTH*k/LATENCY), ceil(WIDTH*(k+1)/LATENCY)) and registers the partial
// sum, the carry out of the slice and the operands still to be processed.
// A new operation is accepted every cycle; data registers only load on valid
// beats, so results hold steady across bubbles.
module full_adder #(
    parameter int WIDTH   = 1,
    parameter int LATENCY = 1
) (
    input  logic         clk,
    input  logic         rst,
    full_adder_if.slave  bus
);

    // First bit index owned by slice k (k == LATENCY gives WIDTH).
    function automatic int stage_bound(input int k);
        return (WIDTH * k + LATENCY - 1) / LATENCY;
    endfunction

    // Classic 1-bit full-adder cell: returns {carry_out, sum}.
    function automatic logic [1:0] fa_cell(input logic ai, input logic bi, input logic ci);
        return {(ai & bi) | (ai & ci) | (bi & ci), ai ^ bi ^ ci};
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < LATENCY; gi++) begin : g_stage
            localparam int LO = stage_bound(gi);
            localparam int HI = stage_bound(gi + 1);

            // Inputs to this slice: either the port operands or the previous slice's registers.
            logic [WIDTH-1:0] a_in;
            logic [WIDTH-1:0] b_in;
            logic [WIDTH-1:0] s_in;
            logic             c_in;
            logic             v_in;

            logic [WIDTH-1:0] sum_next;
            logic             carry_next;

            logic [WIDTH-1:0] sum_reg;
            logic             carry_reg;
            logic             valid_reg;

            if (gi == 0) begin : g_head
                assign a_in = bus.a;
                assign b_in = bus.b;
                assign s_in = '0;
                assign c_in = bus.cin;
                assign v_in = bus.in_valid;
            end else begin : g_link
                assign a_in = g_stage[gi-1].g_fwd.a_reg;
                assign b_in = g_stage[gi-1].g_fwd.b_reg;
                assign s_in = g_stage[gi-1].sum_reg;
                assign c_in = g_stage[gi-1].carry_reg;
                assign v_in = g_stage[gi-1].valid_reg;
            end

            // Ripple the carry through the bits owned by this slice; other sum bits pass through.
            always_comb begin
                logic c;
                c        = c_in;
                sum_next = s_in;
                for (int i = LO; i < HI; i++) begin
                    {c, sum_next[i]} = fa_cell(a_in[i], b_in[i], c);
                end
                carry_next = c;
            end

            // Slice result registers: valid always shifts, data loads only on valid beats.
            always_ff @(posedge clk) begin
                if (rst) begin
                    sum_reg   <= '0;
                    carry_reg <= 1'b0;
                    valid_reg <= 1'b0;
                end else begin
                    valid_reg <= v_in;
                    if (v_in) begin
                        sum_reg   <= sum_next;
                        carry_reg <= carry_next;
                    end
                end
            end

            // Operand forwarding for the slices still to come (absent after the last slice).
            if (gi < LATENCY - 1) begin : g_fwd
                logic [WIDTH-1:0] a_reg;
                logic [WIDTH-1:0] b_reg;

                // Carry the operands along with their partial result.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        a_reg <= '0;
                        b_reg <= '0;
                    end else if (v_in) begin
                        a_reg <= a_in;
                        b_reg <= b_in;
                    end
                end
            end
        end
    endgenerate

    assign bus.sum       = g_stage[LATENCY-1].sum_reg;
    assign bus.carry     = g_stage[LATENCY-1].carry_reg;
    assign bus.out_valid = g_stage[LATENCY-1].valid_reg;

endmodule

// File: tb/tb_full_adder.sv
// Bench for full_adder in three configurations: 1-bit/1-stage, 8-bit/2-stage,
// 8-bit/4-stage. Expected values come from plain a+b+cin arithmetic and a
// queue of results tagged with the clock edge at which they are due.
module tb_full_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst1 = 1'b1;
    logic rst2 = 1'b1;
    logic rst4 = 1'b1;

    full_adder_if #(.WIDTH(1)) if1 ();
    full_adder_if #(.WIDTH(8)) if2 ();
    full_adder_if #(.WIDTH(8)) if4 ();

    full_adder #(.WIDTH(1), .LATENCY(1)) dut1 (.clk(clk), .rst(rst1), .bus(if1.slave));
    full_adder #(.WIDTH(8), .LATENCY(2)) dut2 (.clk(clk), .rst(rst2), .bus(if2.slave));
    full_adder #(.WIDTH(8), .LATENCY(4)) dut4 (.clk(clk), .rst(rst4), .bus(if4.slave));

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        int         due;
        logic [8:0] val;
    } exp_t;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [2:0] got;
        rst1 = 1'b1;
        if1.a = 1'b1; if1.b = 1'b1; if1.cin = 1'b1; if1.in_valid = 1'b1;
        for (int n = 0; n < 2; n++) begin
            tick();
            got = {if1.out_valid, if1.carry, if1.sum};
            vectors++;
            if (got !== 3'b000) begin
                miscompares++;
                $display("FAIL reset_hold[%0d]: got ov/carry/sum=%b, want 000", n, got);
            end else $display("pass reset_hold[%0d]: ov/carry/sum=%b", n, got);
        end
        rst1 = 1'b0;
        tick();
        got = {if1.out_valid, if1.carry, if1.sum};
        vectors++;
        if (got !== 3'b111) begin
            miscompares++;
            $display("FAIL reset_release: got ov/carry/sum=%b, want 111", got);
        end else $display("pass reset_release: ov/carry/sum=%b", got);
    endtask

    task automatic test_truth_table();
        logic [2:0] got;
        logic [1:0] e;
        for (int i = 0; i < 8; i++) begin
            {if1.a, if1.b, if1.cin} = 3'(i);
            if1.in_valid = 1'b1;
            e = 2'(i[2]) + 2'(i[1]) + 2'(i[0]);
            tick();
            got = {if1.out_valid, if1.carry, if1.sum};
            vectors++;
            if (got !== {1'b1, e}) begin
                miscompares++;
                $display("FAIL truth_table[%03b]: got ov/carry/sum=%b, want %b", 3'(i), got, {1'b1, e});
            end else $display("pass truth_table[%03b]: ov/carry/sum=%b", 3'(i), got);
        end
    endtask

    task automatic test_bubbles();
        logic [2:0] got;
        logic [2:0] want [4];
        logic       vin  [4];
        logic [2:0] opnd [4];
        want[0] = 3'b110; want[1] = 3'b010; want[2] = 3'b010; want[3] = 3'b101;
        vin[0]  = 1'b1;   vin[1]  = 1'b0;   vin[2]  = 1'b0;   vin[3]  = 1'b1;
        opnd[0] = 3'b011; opnd[1] = 3'b111; opnd[2] = 3'b000; opnd[3] = 3'b100;
        for (int n = 0; n < 4; n++) begin
            {if1.a, if1.b, if1.cin} = opnd[n];
            if1.in_valid = vin[n];
            tick();
            got = {if1.out_valid, if1.carry, if1.sum};
            vectors++;
            if (got !== want[n]) begin
                miscompares++;
                $display("FAIL bubbles[%0d]: got ov/carry/sum=%b, want %b", n, got, want[n]);
            end else $display("pass bubbles[%0d]: ov/carry/sum=%b", n, got);
        end
        if1.in_valid = 1'b0;
    endtask

    task automatic test_w8_l2();
        logic [9:0] got;
        logic [7:0] av [2];
        logic [7:0] bv [2];
        logic       cv [2];
        logic [8:0] e;
        av[0] = 8'hFF; bv[0] = 8'h00; cv[0] = 1'b1;
        av[1] = 8'h7F; bv[1] = 8'h01; cv[1] = 1'b0;
        if2.in_valid = 1'b0; if2.a = '0; if2.b = '0; if2.cin = 1'b0;
        rst2 = 1'b1;
        tick();
        got = {if2.out_valid, if2.carry, if2.sum};
        vectors++;
        if (got !== 10'd0) begin
            miscompares++;
            $display("FAIL w8l2_reset: got ov/carry/sum=%b, want 0", got);
        end else $display("pass w8l2_reset: ov/carry/sum=%b", got);
        rst2 = 1'b0;
        for (int n = 0; n < 2; n++) begin
            e = {1'b0, av[n]} + {1'b0, bv[n]} + {8'd0, cv[n]};
            if2.a = av[n]; if2.b = bv[n]; if2.cin = cv[n]; if2.in_valid = 1'b1;
            tick();
            if2.in_valid = 1'b0;
            vectors++;
            if (if2.out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL w8l2_early[%0d]: got out_valid=%b, want 0", n, if2.out_valid);
            end else $display("pass w8l2_early[%0d]: out_valid=0", n);
            tick();
            got = {if2.out_valid, if2.carry, if2.sum};
            vectors++;
            if (got !== {1'b1, e}) begin
                miscompares++;
                $display("FAIL w8l2_result[%0d]: got ov/carry/sum=%h, want %h", n, got, {1'b1, e});
            end else $display("pass w8l2_result[%0d]: ov/carry/sum=%h", n, got);
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] exp2 [20];
        logic [9:0] got;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;
        for (int n = 0; n <= 20; n++) begin
            if (n < 20) begin
                ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
                exp2[n] = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
                if2.a = ra; if2.b = rb; if2.cin = rc; if2.in_valid = 1'b1;
            end else begin
                if2.in_valid = 1'b0;
            end
            tick();
            if (n >= 1) begin
                got = {if2.out_valid, if2.carry, if2.sum};
                vectors++;
                if (got !== {1'b1, exp2[n-1]}) begin
                    miscompares++;
                    $display("FAIL back_to_back[%0d]: got ov/carry/sum=%h, want %h", n-1, got, {1'b1, exp2[n-1]});
                end else $display("pass back_to_back[%0d]: ov/carry/sum=%h", n-1, got);
            end
        end
    endtask

    task automatic test_stream();
        exp_t       q[$];
        int         cyc;
        logic [8:0] last;
        logic       exp_v;
        logic       v;
        logic       do_rst;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;
        logic [9:0] got;
        if4.in_valid = 1'b0; if4.a = '0; if4.b = '0; if4.cin = 1'b0;
        rst4 = 1'b1;
        tick();
        got = {if4.out_valid, if4.carry, if4.sum};
        vectors++;
        if (got !== 10'd0) begin
            miscompares++;
            $display("FAIL w8l4_reset: got ov/carry/sum=%h, want 0", got);
        end else $display("pass w8l4_reset: ov/carry/sum=%h", got);
        cyc  = 0;
        last = 9'd0;
        for (int s = 0; s < 400; s++) begin
            do_rst = (s == 180);
            if (s < 256)      v = 1'b1;
            else if (s < 260) v = 1'b0;
            else if (s < 392) v = ($urandom_range(0, 9) > 2);
            else              v = 1'b0;
            if (s == 5)       begin ra = 8'hFF; rb = 8'h00; rc = 1'b1; end
            else if (s == 6)  begin ra = 8'hFF; rb = 8'hFF; rc = 1'b1; end
            else if (s == 7)  begin ra = 8'h00; rb = 8'h00; rc = 1'b0; end
            else begin ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom); end
            rst4 = do_rst;
            if4.a = ra; if4.b = rb; if4.cin = rc; if4.in_valid = v;
            // A result is due LATENCY-1 edges after the edge that samples it.
            if (do_rst) begin
                q.delete();
                last = 9'd0;
            end else if (v) begin
                q.push_back('{cyc + 4, {1'b0, ra} + {1'b0, rb} + {8'd0, rc}});
            end
            tick();
            cyc++;
            exp_v = 1'b0;
            if (q.size() > 0 && q[0].due == cyc) begin
                exp_v = 1'b1;
                last  = q[0].val;
                void'(q.pop_front());
            end
            got = {if4.out_valid, if4.carry, if4.sum};
            vectors++;
            if (got !== {exp_v, last}) begin
                miscompares++;
                $display("FAIL stream[%0d]: got ov/carry/sum=%h, want %h", s, got, {exp_v, last});
            end else $display("pass stream[%0d]: ov/carry/sum=%h", s, got);
        end
        rst4 = 1'b0;
    endtask

    initial begin
        if1.in_valid = 1'b0; if1.a = '0; if1.b = '0; if1.cin = 1'b0;
        if2.in_valid = 1'b0; if2.a = '0; if2.b = '0; if2.cin = 1'b0;
        if4.in_valid = 1'b0; if4.a = '0; if4.b = '0; if4.cin = 1'b0;
        #2;
        test_reset();
        test_truth_table();
        test_bubbles();
        test_w8_l2();
        test_back_to_back();
        test_stream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
